sdram_responder: RTL and testbench

- Memory-side responder for the KNN SDRAM master port. It serves the `read`/`readaddress`/`readdata` and `write`/`writeaddress`/`writedata` strobes issued by the KNN controller.
- Backed by an internal word array, with fixed read latency and a multi-cycle write-occupancy model.
- Replaces behavioural memory models in system-level simulation and provides a synthesizable on-chip stand-in for the SDRAM.
- Addresses are bit addresses and must be multiples of W. The word index is `address / W`.

---
 rtl/sdram_responder.sv | 188 ++++++++++++++++++
 tb/tb_sdram_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// sdram_responder: memory-side responder for the KNN SDRAM master port.
// Serves edge-triggered read/write strobes from an internal word array with a
// fixed read latency and a multi-cycle write occupancy window.
// Optional: define SDRAM_RESPONDER_STATS_EN to add rd_count/wr_count outputs.
module sdram_responder #(
    parameter int W            = 16,
    parameter int ADDR_W       = 25,
    parameter int DEPTH        = 8448,
    parameter int READ_LAT     = 1,
    parameter int WRITE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic [ADDR_W-1:0] readaddress,
    output logic [W-1:0]      readdata,
    output logic              readdatavalid,
    input  logic              write,
    input  logic [ADDR_W-1:0] writeaddress,
    input  logic [W-1:0]      writedata,
    output logic              write_done,
    output logic              busy,
    output logic              addr_err,
    output logic              overflow
`ifdef SDRAM_RESPONDER_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(W);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
    } req_t;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_HOLD} state_t;

    // Bit address -> word legality and index
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ((a % W_A) == '0) && ((a / W_A) < DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a / W_A);
    endfunction

    logic [W-1:0] mem [DEPTH];

    logic         rd_q, wr_q;
    req_t         rd_slot, wr_slot;
    logic [W-1:0] wr_data;
    state_t       state, state_n;
    logic [7:0]   cnt, cnt_n;
    logic         rd_take, wr_take, done_n;

    // Next-state and strobe outputs; writes win when both slots are full
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        rd_take       = 1'b0;
        wr_take       = 1'b0;
        done_n        = 1'b0;
        readdatavalid = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (wr_slot.vld) begin
                    wr_take = 1'b1;
                    state_n = WR_HOLD;
                    cnt_n   = 8'(WRITE_CYCLES - 1);
                end else if (rd_slot.vld) begin
                    rd_take = 1'b1;
                    state_n = RD_WAIT;
                    cnt_n   = 8'(READ_LAT - 1);
                end
            end
            RD_WAIT: begin
                if (cnt == 8'd0) begin
                    readdatavalid = 1'b1;
                    state_n       = IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            WR_HOLD: begin
                if (cnt == 8'd0) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; write_done lands in the first IDLE cycle after occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            write_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            write_done <= done_n;
        end
    end

    // Edge detect and one-deep pending slots; a slot being drained this cycle can refill
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rd_slot  <= '0;
            wr_slot  <= '0;
            wr_data  <= '0;
            overflow <= 1'b0;
        end else begin
            rd_q <= read;
            wr_q <= write;
            if (read && !rd_q) begin
                if (rd_slot.vld && !rd_take) begin
                    overflow <= 1'b1;
                end else begin
                    rd_slot.vld  <= 1'b1;
                    rd_slot.addr <= readaddress;
                end
            end else if (rd_take) begin
                rd_slot.vld <= 1'b0;
            end
            if (write && !wr_q) begin
                if (wr_slot.vld && !wr_take) begin
                    overflow <= 1'b1;
                end else begin
                    wr_slot.vld  <= 1'b1;
                    wr_slot.addr <= writeaddress;
                    wr_data      <= writedata;
                end
            end else if (wr_take) begin
                wr_slot.vld <= 1'b0;
            end
        end
    end

    // Read data captured on RD_WAIT entry; illegal addresses return zero and flag
    always_ff @(posedge clk) begin
        if (rst) begin
            readdata <= '0;
            addr_err <= 1'b0;
        end else begin
            if (rd_take) begin
                readdata <= addr_ok(rd_slot.addr) ? mem[word_idx(rd_slot.addr)] : '0;
                if (!addr_ok(rd_slot.addr))
                    addr_err <= 1'b1;
            end
            if (wr_take && !addr_ok(wr_slot.addr))
                addr_err <= 1'b1;
        end
    end

    // Memory commit on WR_HOLD entry; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_take && !rst && addr_ok(wr_slot.addr))
            mem[word_idx(wr_slot.addr)] <= wr_data;
    end

`ifdef SDRAM_RESPONDER_STATS_EN
    // Saturating completion counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else begin
            if (readdatavalid && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
            if (write_done && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed self-checking bench for sdram_responder.
// Covers SDRAM_RESPONDER_STATS_EN counters when that macro is defined.
module tb_sdram_responder;

    localparam int W     = 16;
    localparam int AW    = 25;
    localparam int DEPTH = 8448;

    logic          clk = 1'b0;
    logic          rst, read, write;
    logic [AW-1:0] readaddress, writeaddress;
    logic [W-1:0]  writedata, readdata;
    logic          readdatavalid, write_done, busy, addr_err, overflow;
`ifdef SDRAM_RESPONDER_STATS_EN
    logic [15:0]   rd_count, wr_count;
`endif

    int            n_chk = 0;
    int            n_fail = 0;
    int            rv_cnt = 0;
    int            dn_cnt = 0;
    logic [W-1:0]  rv_last = '0;

    always #5 clk = ~clk;

    sdram_responder #(
        .W(W), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(1), .WRITE_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .read(read), .readaddress(readaddress), .readdata(readdata),
        .readdatavalid(readdatavalid),
        .write(write), .writeaddress(writeaddress), .writedata(writedata),
        .write_done(write_done), .busy(busy), .addr_err(addr_err),
        .overflow(overflow)
`ifdef SDRAM_RESPONDER_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (readdatavalid) begin
            rv_cnt  <= rv_cnt + 1;
            rv_last <= readdata;
        end
        if (write_done)
            dn_cnt <= dn_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one write edge and watch the occupancy window
    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d,
                            output int bcnt, output int dcnt, output int didx);
        writeaddress = a;
        writedata    = d;
        write        = 1'b1;
        tick();
        write = 1'b0;
        bcnt = 0; dcnt = 0; didx = -1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (busy) bcnt++;
            if (write_done) begin
                dcnt++;
                if (didx < 0) didx = i;
            end
        end
    endtask

    // Issue one read edge; lat is cycles from capture edge to valid (-1 if none)
    task automatic do_read(input logic [AW-1:0] a, output logic [W-1:0] d, output int lat);
        readaddress = a;
        read        = 1'b1;
        tick();
        read = 1'b0;
        lat  = -1;
        d    = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (readdatavalid && lat < 0) begin
                lat = i;
                d   = readdata;
            end
        end
    endtask

    initial begin
        logic [W-1:0] d;
        int b, dn, di, lat, v0, d0, vi;

        rst = 1'b1; read = 1'b0; write = 1'b0;
        readaddress = '0; writeaddress = '0; writedata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy",     32'(busy),          32'd0);
        chk("rst_rvalid",   32'(readdatavalid), 32'd0);
        chk("rst_wdone",    32'(write_done),    32'd0);
        chk("rst_addr_err", 32'(addr_err),      32'd0);
        chk("rst_overflow", 32'(overflow),      32'd0);
        chk("rst_rdata",    32'(readdata),      32'd0);

        // 1: write word 2, busy 8 cycles, write_done in the following cycle
        do_write(25'd32, 16'h00A5, b, dn, di);
        chk("wr_busy_cycles", 32'(b),  32'd8);
        chk("wr_done_count",  32'(dn), 32'd1);
        chk("wr_done_idx",    32'(di), 32'd8);
        do_read(25'd32, d, lat);
        chk("rd_data_w2", 32'(d),   32'h00A5);
        chk("rd_lat_w2",  32'(lat), 32'd1);

        // 2: held-high read is a single request
        do_write(25'd0, 16'h0000, b, dn, di);
        v0 = rv_cnt;
        readaddress = 25'd0;
        read = 1'b1;
        repeat (5) tick();
        read = 1'b0;
        repeat (5) tick();
        chk("held_rd_pulses", 32'(rv_cnt - v0), 32'd1);
        chk("held_rd_data",   32'(rv_last),     32'd0);
        chk("held_rd_no_ovf", 32'(overflow),    32'd0);

        // 3: simultaneous write+read to word 3, write first, read sees new data
        writeaddress = 25'd48; writedata = 16'h1234; readaddress = 25'd48;
        write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        di = -1; vi = -1; d = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (write_done && di < 0) di = i;
            if (readdatavalid && vi < 0) begin
                vi = i;
                d  = readdata;
            end
        end
        chk("raw_done_idx", 32'(di),      32'd8);
        chk("raw_gap",      32'(vi - di), 32'd1);
        chk("raw_data",     32'(d),       32'h1234);

        // 4: illegal addresses; preload neighbours to expose stray writes/reads
        do_write(25'd16, 16'h1111, b, dn, di);
        do_write(25'(W * (DEPTH - 1)), 16'h0F0F, b, dn, di);
        chk("pre_addr_err", 32'(addr_err), 32'd0);
        do_read(25'(W * DEPTH), d, lat);
        chk("oor_rd_data",  32'(d),        32'd0);
        chk("oor_rd_lat",   32'(lat),      32'd1);
        chk("oor_addr_err", 32'(addr_err), 32'd1);
        do_read(25'd17, d, lat);
        chk("mis_rd_data", 32'(d),   32'd0);
        chk("mis_rd_lat",  32'(lat), 32'd1);
        do_write(25'(W * DEPTH), 16'hBEEF, b, dn, di);
        chk("oor_wr_busy", 32'(b),  32'd8);
        chk("oor_wr_done", 32'(dn), 32'd1);
        do_write(25'd33, 16'hDEAD, b, dn, di);
        chk("mis_wr_busy", 32'(b), 32'd8);
        do_read(25'd32, d, lat);
        chk("keep_w2", 32'(d), 32'h00A5);
        do_read(25'd16, d, lat);
        chk("keep_w1", 32'(d), 32'h1111);
        do_read(25'(W * (DEPTH - 1)), d, lat);
        chk("keep_last", 32'(d), 32'h0F0F);
        chk("addr_err_sticky", 32'(addr_err), 32'd1);

        // 5: two read edges during WR_HOLD; second is lost
        writeaddress = 25'd64; writedata = 16'h5555; write = 1'b1;
        tick();
        write = 1'b0;
        repeat (2) tick();
        v0 = rv_cnt;
        readaddress = 25'd32; read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        chk("ovf_before", 32'(overflow), 32'd0);
        readaddress = 25'd48; read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        chk("ovf_set", 32'(overflow), 32'd1);
        repeat (20) tick();
        chk("ovf_pulses", 32'(rv_cnt - v0), 32'd1);
        chk("ovf_kept_old", 32'(rv_last), 32'h00A5);

        // 6: reset 3 cycles into WR_HOLD
        writeaddress = 25'd80; writedata = 16'h7777; write = 1'b1;
        tick();
        write = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        d0 = dn_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",     32'(busy),     32'd0);
        chk("abort_ovf_clr",  32'(overflow), 32'd0);
        chk("abort_aerr_clr", 32'(addr_err), 32'd0);
        repeat (12) tick();
        chk("abort_no_done", 32'(dn_cnt - d0), 32'd0);
`ifdef SDRAM_RESPONDER_STATS_EN
        chk("stat_wr_rst", 32'(wr_count), 32'd0);
        chk("stat_rd_rst", 32'(rd_count), 32'd0);
`endif
        do_read(25'd80, d, lat);
        chk("abort_committed", 32'(d), 32'h7777);
        do_write(25'd96, 16'h0001, b, dn, di);
        chk("post_rst_wr_done", 32'(dn), 32'd1);
`ifdef SDRAM_RESPONDER_STATS_EN
        chk("stat_wr_one", 32'(wr_count), 32'd1);
        chk("stat_rd_one", 32'(rd_count), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
